// File: rtl/ramcard_pkg.sv
// ramcard_pkg: shared types and constants for the RAM-card arbiter.
//   state_t : access FSM states (IDLE, ISSUE, WAIT, DONE)
//   owner_t : which port owns the current access (OWN_CPU, OWN_DMA)
//   RAM_AW / RAM_DW : card RAM address / data widths
package ramcard_pkg;

    localparam int RAM_AW = 18;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_DMA
    } owner_t;

endpackage

// File: rtl/ramcard_arb_prio.sv
// ramcard_arb_prio: grant decision between the CPU and DMA ports, plus the
// starvation counter that bounds consecutive CPU grants while DMA waits.
// Build option: RAMCARD_DMA_EN enables the DMA side; without it only the CPU
// can be granted and no starvation counter exists.
// Ports:
//   clk, reset_in    : clock, synchronous active-high reset
//   sample           : high while the FSM is in IDLE (requests may be taken)
//   cpu_req, dma_req : request levels
//   grant            : a grant happens this cycle
//   owner            : winner of this cycle's grant
module ramcard_arb_prio
    import ramcard_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset_in,
    input  logic   sample,
    input  logic   cpu_req,
    input  logic   dma_req,
    output logic   grant,
    output owner_t owner
);

`ifdef RAMCARD_DMA_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_comb begin
        grant = sample & (cpu_req | dma_req);
        owner = OWN_CPU;
        // DMA wins when alone, or when the CPU has had its share.
        if (dma_req && (!cpu_req || (starve_cnt >= LIMIT))) begin
            owner = OWN_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (owner == OWN_DMA) begin
                starve_cnt <= '0;
            end else if (dma_req) begin
                if (starve_cnt != 4'hF) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`else
    logic unused_prio;

    assign grant       = sample & cpu_req;
    assign owner       = OWN_CPU;
    assign unused_prio = &{1'b0, clk, reset_in, dma_req};
`endif

endmodule

// File: rtl/ramcard_arbiter.sv
// ramcard_arbiter: shares one card RAM port between the CPU and a host DMA
// port. Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE.
// Build option: RAMCARD_DMA_EN enables the DMA port; without it dma_ack and
// dma_rdata are tied 0 and the DMA inputs are ignored.
// Ports:
//   clk, reset_in                        : clock, synchronous active-high reset
//   cpu_req/addr/we/wdata, cpu_rdata/ack : CPU access port
//   dma_req/addr/we/wdata, dma_rdata/ack : host DMA access port
//   mem_addr/we/rd/wdata, mem_rdata      : shared card RAM port
module ramcard_arbiter
    import ramcard_pkg::*;
#(
    parameter int unsigned MEM_LAT      = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              cpu_req,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [RAM_DW-1:0] cpu_wdata,
    output logic [RAM_DW-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic [RAM_AW-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [RAM_DW-1:0] dma_wdata,
    output logic [RAM_DW-1:0] dma_rdata,
    output logic              dma_ack,
    output logic [RAM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_rd,
    output logic [RAM_DW-1:0] mem_wdata,
    input  logic [RAM_DW-1:0] mem_rdata
);

    state_t            state;
    logic              req_we;
    logic [2:0]        wait_cnt;
    logic              grant;
    owner_t            owner;
    logic [RAM_AW-1:0] sel_addr;
    logic              sel_we;
    logic [RAM_DW-1:0] sel_wdata;

    ramcard_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk     (clk),
        .reset_in(reset_in),
        .sample  (state == IDLE),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .grant   (grant),
        .owner   (owner)
    );

`ifdef RAMCARD_DMA_EN
    owner_t own;

    always_comb begin
        sel_addr  = cpu_addr;
        sel_we    = cpu_we;
        sel_wdata = cpu_wdata;
        if (owner == OWN_DMA) begin
            sel_addr  = dma_addr;
            sel_we    = dma_we;
            sel_wdata = dma_wdata;
        end
    end
`else
    logic unused_dma;

    assign sel_addr   = cpu_addr;
    assign sel_we     = cpu_we;
    assign sel_wdata  = cpu_wdata;
    assign dma_ack    = 1'b0;
    assign dma_rdata  = '0;
    assign unused_dma = &{1'b0, dma_addr, dma_we, dma_wdata, owner == OWN_DMA};
`endif

    // Strobes, ack and rdata are registered: they are loaded on the edge that
    // enters ISSUE / DONE so they are visible during those states. The read
    // data sampled at the end of the last WAIT cycle is cycle T+MEM_LAT.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
`ifdef RAMCARD_DMA_EN
            own       <= OWN_CPU;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
`endif
        end else begin
            mem_rd  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_ack <= 1'b0;
`ifdef RAMCARD_DMA_EN
            dma_ack <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant) begin
                        req_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_rd    <= ~sel_we;
                        mem_we    <= sel_we;
`ifdef RAMCARD_DMA_EN
                        own       <= owner;
`endif
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 3'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= DONE;
`ifdef RAMCARD_DMA_EN
                        if (own == OWN_DMA) begin
                            dma_ack <= 1'b1;
                            if (!req_we) begin
                                dma_rdata <= mem_rdata;
                            end
                        end else
`endif
                        begin
                            cpu_ack <= 1'b1;
                            if (!req_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ramcard_arbiter.sv
// tb_ramcard_arbiter: directed self-checking bench for ramcard_arbiter.
// u_dut uses the defaults (MEM_LAT=2, STARVE_LIMIT=4); u_dut_b uses
// STARVE_LIMIT=0 for the DMA-first case. DMA expectations follow
// RAMCARD_DMA_EN.
module tb_ramcard_arbiter;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [17:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic [7:0]  cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic [17:0] mem_addr;
    logic        mem_we, mem_rd;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  mem_val;
    logic        rd_d1 = 1'b0, rd_d2 = 1'b0;

    logic        cpu_req_b, dma_req_b;
    logic [7:0]  cpu_rdata_b, dma_rdata_b, mem_wdata_b;
    logic        cpu_ack_b, dma_ack_b, mem_we_b, mem_rd_b;
    logic [17:0] mem_addr_b;
    logic [7:0]  mem_rdata_b = 8'h00;

    int passed = 0;
    int total = 0;
    int strobe_viol = 0;
    int both_ack = 0;
    int dma_ack_seen = 0;

    always #5 clk = ~clk;

    ramcard_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset_in(reset_in),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    ramcard_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(0)) u_dut_b (
        .clk(clk), .reset_in(reset_in),
        .cpu_req(cpu_req_b), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b),
        .dma_req(dma_req_b), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata_b), .dma_ack(dma_ack_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_rd(mem_rd_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // RAM model with a fixed 2-cycle read latency: mem_val appears only in
    // cycle T+2 after a read strobe in cycle T, 0xEE otherwise.
    always @(posedge clk) begin
        rd_d1 <= mem_rd;
        rd_d2 <= rd_d1;
    end
    assign mem_rdata = rd_d2 ? mem_val : 8'hEE;

    always @(negedge clk) begin
        if ((mem_rd && mem_we) || (mem_rd_b && mem_we_b)) strobe_viol++;
        if (cpu_ack && dma_ack) both_ack++;
        if (dma_ack) dma_ack_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int cyc;
        int first_ack;
        int second_ack;
        logic got_dma [10];
        logic exp_dma;
        logic [7:0] exp_dma_rdata;

        reset_in = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        cpu_req_b = 1'b0; dma_req_b = 1'b0;
        mem_val = 8'h00;
        tick(); tick(); tick();

        // Reset state
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_dma_ack", dma_ack, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_mem_addr", mem_addr, 18'h0);

        // CPU read of 0x2A000, granted in the first cycle after reset falls
        reset_in = 1'b0;
        cpu_req = 1'b1; cpu_addr = 18'h2A000; cpu_we = 1'b0;
        mem_val = 8'h5C;
        tick();
        check("rd_issue_rd", mem_rd, 1'b1);
        check("rd_issue_we", mem_we, 1'b0);
        check("rd_issue_addr", mem_addr, 18'h2A000);
        check("rd_issue_ack", cpu_ack, 1'b0);
        // inputs changing mid-access must not disturb it
        cpu_addr = 18'h3FFFF; cpu_we = 1'b1; cpu_wdata = 8'hFF;
        tick();
        check("rd_wait1_rd", mem_rd, 1'b0);
        check("rd_wait1_addr", mem_addr, 18'h2A000);
        tick();
        check("rd_wait2_ack", cpu_ack, 1'b0);
        tick();
        check("rd_done_ack", cpu_ack, 1'b1);
        check("rd_done_rdata", cpu_rdata, 8'h5C);
        cpu_req = 1'b0;
        tick();
        check("rd_ack_pulse", cpu_ack, 1'b0);
        check("rd_rdata_hold", cpu_rdata, 8'h5C);

        // CPU write 0x11 to 0x00010
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00010; cpu_wdata = 8'h11;
        mem_val = 8'h77;
        tick();
        check("wr_issue_we", mem_we, 1'b1);
        check("wr_issue_rd", mem_rd, 1'b0);
        check("wr_issue_addr", mem_addr, 18'h00010);
        check("wr_issue_wdata", mem_wdata, 8'h11);
        tick();
        check("wr_we_pulse", mem_we, 1'b0);
        tick();
        check("wr_wait_ack", cpu_ack, 1'b0);
        tick();
        check("wr_done_ack", cpu_ack, 1'b1);
        check("wr_rdata_kept", cpu_rdata, 8'h5C);
        cpu_req = 1'b0;
        tick();

        // Both ports held high: CPU writes, DMA reads
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00020; cpu_wdata = 8'h33;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 18'h00001;
        mem_val = 8'hA5;
        n = 0; cyc = 0; first_ack = -1; second_ack = -1;
        while (n < 10 && cyc < 100) begin
            tick();
            cyc++;
            if (cpu_ack || dma_ack) begin
                got_dma[n] = dma_ack;
                if (n == 0) first_ack = cyc;
                if (n == 1) second_ack = cyc;
                n++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("arb_ack_count", n, 10);
        check("arb_first_latency", first_ack, 4);
        check("arb_throughput", second_ack - first_ack, 5);
        for (int i = 0; i < 10; i++) begin
`ifdef RAMCARD_DMA_EN
            exp_dma = (i == 4 || i == 9);
`else
            exp_dma = 1'b0;
`endif
            check($sformatf("arb_owner_%0d", i), (i < n) ? got_dma[i] : 1'bx, exp_dma);
        end
`ifdef RAMCARD_DMA_EN
        exp_dma_rdata = 8'hA5;
`else
        exp_dma_rdata = 8'h00;
`endif
        check("arb_dma_rdata", dma_rdata, exp_dma_rdata);
        check("arb_cpu_rdata", cpu_rdata, 8'h5C);
        tick(); tick(); tick(); tick(); tick(); tick();

        // Reset pulsed while an access sits in WAIT
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00155;
        tick();
        check("rst_mid_issue", mem_rd, 1'b1);
        tick();
        reset_in = 1'b1;
        tick();
        check("rst_mid_ack", cpu_ack, 1'b0);
        check("rst_mid_rd", mem_rd, 1'b0);
        check("rst_mid_we", mem_we, 1'b0);
        check("rst_mid_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_mid_dma_rdata", dma_rdata, 8'h00);
        check("rst_mid_addr", mem_addr, 18'h0);
        check("rst_mid_wdata", mem_wdata, 8'h00);
        reset_in = 1'b0;
        tick();
        check("rst_regrant_rd", mem_rd, 1'b1);
        check("rst_regrant_addr", mem_addr, 18'h00155);
        check("rst_regrant_noack", cpu_ack, 1'b0);
        tick();
        tick();
        check("rst_regrant_wait", cpu_ack, 1'b0);
        tick();
        check("rst_regrant_ack", cpu_ack, 1'b1);
        cpu_req = 1'b0;
        tick(); tick();

`ifdef RAMCARD_DMA_EN
        // STARVE_LIMIT=0: simultaneous requests grant DMA first
        cpu_req_b = 1'b1; dma_req_b = 1'b1;
        cyc = 0;
        while (!(cpu_ack_b || dma_ack_b) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("lim0_first_dma", dma_ack_b, 1'b1);
        check("lim0_first_not_cpu", cpu_ack_b, 1'b0);
        dma_req_b = 1'b0;
        cyc = 0;
        tick();
        while (!cpu_ack_b && cyc < 20) begin
            tick();
            cyc++;
        end
        check("lim0_then_cpu", cpu_ack_b, 1'b1);
        cpu_req_b = 1'b0;
        tick(); tick();
        check("no_both_acks", both_ack, 0);
`else
        check("dma_ack_never", dma_ack_seen, 0);
`endif
        check("strobe_exclusive", strobe_viol, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
